// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry in-order-retire ROB with dual CDB capture and operand lookup; define ROB_CDB_BYPASS_EN to forward same-cycle CDB results to lookup
module reorder_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_dest,
  output logic        alloc_ready,
  output logic [5:0]  alloc_robNum,
  input  logic        CDBiscast,
  input  logic [5:0]  CDBrobNum,
  input  logic [31:0] CDBdata,
  input  logic        CDBiscast2,
  input  logic [5:0]  CDBrobNum2,
  input  logic [31:0] CDBdata2,
  input  logic [5:0]  index,
  output logic        ready,
  output logic [31:0] value,
  input  logic        flush,
  output logic        commit_valid,
  output logic [4:0]  commit_dest,
  output logic [31:0] commit_data,
  output logic [5:0]  commit_robNum,
  output logic [4:0]  count
);
  localparam int ENTRIES = 16;
  localparam logic [5:0] INVALID_TAG = 6'b010000;
  logic [ENTRIES-1:0] busy_q, busy_d, done_q, done_d;
  logic [4:0] dest_q [ENTRIES];
  logic [4:0] dest_d [ENTRIES];
  logic [31:0] data_q [ENTRIES];
  logic [31:0] data_d [ENTRIES];
  logic [3:0] head_q, head_d, tail_q, tail_d;
  logic [4:0] count_q, count_d;
  logic commit_valid_q;
  logic [4:0] commit_dest_q;
  logic [31:0] commit_data_q;
  logic [5:0] commit_robNum_q;
  logic alloc_ok, commit_ok, wb1, wb2, in_rng, stored;
  logic [3:0] li;
  assign alloc_ready = !count_q[4];
  assign alloc_robNum = {2'b00, tail_q};
  assign alloc_ok = alloc_valid && alloc_ready;
  assign commit_ok = busy_q[head_q] && done_q[head_q];
  // A write targets only entries already busy before this edge, so a same-edge allocation is never hit
  assign wb1 = CDBiscast && CDBrobNum[5:4] == 2'b00 && busy_q[CDBrobNum[3:0]];
  assign wb2 = CDBiscast2 && CDBrobNum2[5:4] == 2'b00 && busy_q[CDBrobNum2[3:0]];
  assign head_d = head_q + {3'b000, commit_ok};
  assign tail_d = tail_q + {3'b000, alloc_ok};
  assign count_d = count_q + {4'b0000, alloc_ok} - {4'b0000, commit_ok};
  // Next entry state: port 2 then port 1 writeback so port 1 wins a shared tag, then retire, then allocate
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    dest_d = dest_q;
    data_d = data_q;
    if (wb2) begin
      done_d[CDBrobNum2[3:0]] = 1'b1;
      data_d[CDBrobNum2[3:0]] = CDBdata2;
    end
    if (wb1) begin
      done_d[CDBrobNum[3:0]] = 1'b1;
      data_d[CDBrobNum[3:0]] = CDBdata;
    end
    if (commit_ok) busy_d[head_q] = 1'b0;
    if (alloc_ok) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      dest_d[tail_q] = alloc_dest;
    end
  end
  // Control state: reset and flush both empty the buffer
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      busy_q <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      commit_valid_q <= commit_ok;
    end
  end
  // Retire payload holds its last value between commits; flush leaves it untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      commit_dest_q <= '0;
      commit_data_q <= '0;
      commit_robNum_q <= INVALID_TAG;
    end else if (!flush && commit_ok) begin
      commit_dest_q <= dest_q[head_q];
      commit_data_q <= data_q[head_q];
      commit_robNum_q <= {2'b00, head_q};
    end
  end
  // Payload storage needs no reset: it is only observed through busy/done qualified paths
  always_ff @(posedge clock) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end
  assign li = index[3:0];
  assign in_rng = index[5:4] == 2'b00;
  assign stored = in_rng && busy_q[li] && done_q[li];
`ifdef ROB_CDB_BYPASS_EN
  logic pend, byp1, byp2;
  assign pend = in_rng && busy_q[li] && !done_q[li];
  assign byp1 = pend && CDBiscast && CDBrobNum == index;
  assign byp2 = pend && CDBiscast2 && CDBrobNum2 == index;
  // Lookup prefers stored results, then same-cycle CDB port 1, then port 2
  always_comb begin
    ready = stored || byp1 || byp2;
    value = stored ? data_q[li] : byp1 ? CDBdata : byp2 ? CDBdata2 : 32'h0;
  end
`else
  // Lookup sees stored results only
  always_comb begin
    ready = stored;
    value = stored ? data_q[li] : 32'h0;
  end
`endif
  assign count = count_q;
  assign commit_valid = commit_valid_q;
  assign commit_dest = commit_dest_q;
  assign commit_data = commit_data_q;
  assign commit_robNum = commit_robNum_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of allocation, writeback, in-order commit, lookup and flush
module tb_reorder_buffer;
  logic clock = 1'b0, reset = 1'b0, alloc_valid = 1'b0, CDBiscast = 1'b0, CDBiscast2 = 1'b0, flush = 1'b0;
  logic [4:0] alloc_dest = '0;
  logic [5:0] CDBrobNum = '0, CDBrobNum2 = '0, index = '0;
  logic [31:0] CDBdata = '0, CDBdata2 = '0;
  logic alloc_ready, ready, commit_valid;
  logic [5:0] alloc_robNum, commit_robNum;
  logic [31:0] value, commit_data;
  logic [4:0] commit_dest, count;
  int checks = 0, errors = 0;
`ifdef ROB_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  reorder_buffer dut (
    .clock(clock), .reset(reset), .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_robNum(alloc_robNum),
    .CDBiscast(CDBiscast), .CDBrobNum(CDBrobNum), .CDBdata(CDBdata),
    .CDBiscast2(CDBiscast2), .CDBrobNum2(CDBrobNum2), .CDBdata2(CDBdata2),
    .index(index), .ready(ready), .value(value), .flush(flush),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_data(commit_data),
    .commit_robNum(commit_robNum), .count(count)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic idle;
    alloc_valid = 0; CDBiscast = 0; CDBiscast2 = 0; flush = 0; reset = 0;
  endtask
  task automatic do_reset;
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask
  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1; alloc_dest = 5'(i);
      tick();
    end
    alloc_valid = 0;
  endtask
  task automatic cdb1(input logic [5:0] tag, input logic [31:0] d);
    CDBiscast = 1; CDBrobNum = tag; CDBdata = d;
    tick();
    CDBiscast = 0;
  endtask
  task automatic test_reset;
    do_reset();
    index = 0;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0b exp 1", alloc_ready); end
    checks++; if (alloc_robNum !== 6'd0) begin errors++; $display("FAIL reset_alloc_robNum got %0d exp 0", alloc_robNum); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %0b exp 0", commit_valid); end
    checks++; if (commit_robNum !== 6'd16) begin errors++; $display("FAIL reset_commit_robNum got %0d exp 16", commit_robNum); end
    checks++; if (commit_dest !== 5'd0 || commit_data !== 32'd0) begin errors++; $display("FAIL reset_payload got %0d/%h exp 0/0", commit_dest, commit_data); end
    checks++; if (ready !== 1'b0 || value !== 32'd0) begin errors++; $display("FAIL reset_lookup got %0b/%h exp 0/0", ready, value); end
  endtask
  task automatic test_basic;
    do_reset();
    alloc_valid = 1; alloc_dest = 5;
    #1;
    checks++; if (alloc_robNum !== 6'd0) begin errors++; $display("FAIL basic_tag got %0d exp 0", alloc_robNum); end
    tick();
    alloc_valid = 0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", count); end
    cdb1(0, 32'h1234);
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL basic_early_commit got %0b exp 0", commit_valid); end
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd5 || commit_data !== 32'h1234 || commit_robNum !== 6'd0)
      begin errors++; $display("FAIL basic_commit got v%0b d%0d %h r%0d exp v1 d5 1234 r0", commit_valid, commit_dest, commit_data, commit_robNum); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL basic_count_after got %0d exp 0", count); end
    tick();
    checks++; if (commit_valid !== 1'b0 || commit_data !== 32'h1234) begin errors++; $display("FAIL basic_hold got v%0b %h exp v0 1234", commit_valid, commit_data); end
  endtask
  task automatic test_out_of_order;
    logic [31:0] exp_data [3];
    exp_data[0] = 5; exp_data[1] = 6; exp_data[2] = 7;
    do_reset();
    alloc_n(3);
    cdb1(2, 7);
    cdb1(1, 6);
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_premature got %0b exp 0", commit_valid); end
    cdb1(0, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (commit_valid !== 1'b1 || commit_robNum !== 6'(i) || commit_data !== exp_data[i] || count !== 5'(2 - i))
        begin errors++; $display("FAIL ooo_commit%0d got v%0b r%0d %h c%0d exp v1 r%0d %h c%0d", i, commit_valid, commit_robNum, commit_data, count, i, exp_data[i], 2 - i); end
    end
  endtask
  task automatic test_full_wrap;
    do_reset();
    alloc_n(16);
    checks++; if (count !== 5'd16 || alloc_ready !== 1'b0 || alloc_robNum !== 6'd0)
      begin errors++; $display("FAIL full_state got c%0d rdy%0b t%0d exp c16 rdy0 t0", count, alloc_ready, alloc_robNum); end
    alloc_valid = 1; alloc_dest = 31;
    tick();
    alloc_valid = 0;
    checks++; if (count !== 5'd16 || alloc_robNum !== 6'd0) begin errors++; $display("FAIL full_reject got c%0d t%0d exp c16 t0", count, alloc_robNum); end
    cdb1(0, 32'hAA);
    alloc_valid = 1; alloc_dest = 9;
    tick();
    alloc_valid = 0;
    checks++; if (commit_valid !== 1'b1 || commit_robNum !== 6'd0 || commit_data !== 32'hAA || commit_dest !== 5'd0 || count !== 5'd15)
      begin errors++; $display("FAIL full_commit got v%0b r%0d %h d%0d c%0d exp v1 r0 aa d0 c15", commit_valid, commit_robNum, commit_data, commit_dest, count); end
    checks++; if (alloc_ready !== 1'b1 || alloc_robNum !== 6'd0) begin errors++; $display("FAIL wrap_tag got rdy%0b t%0d exp rdy1 t0", alloc_ready, alloc_robNum); end
    alloc_n(1);
    checks++; if (count !== 5'd16 || alloc_robNum !== 6'd1) begin errors++; $display("FAIL wrap_alloc got c%0d t%0d exp c16 t1", count, alloc_robNum); end
  endtask
  task automatic test_dual_cdb;
    do_reset();
    alloc_n(5);
    CDBiscast = 1; CDBrobNum = 3; CDBdata = 8; CDBiscast2 = 1; CDBrobNum2 = 3; CDBdata2 = 9;
    tick();
    idle();
    index = 3; #1;
    checks++; if (ready !== 1'b1 || value !== 32'd8) begin errors++; $display("FAIL dual_same_tag got %0b/%0d exp 1/8", ready, value); end
    CDBiscast = 1; CDBrobNum = 1; CDBdata = 11; CDBiscast2 = 1; CDBrobNum2 = 2; CDBdata2 = 22;
    tick();
    idle();
    index = 1; #1;
    checks++; if (ready !== 1'b1 || value !== 32'd11) begin errors++; $display("FAIL dual_port1 got %0b/%0d exp 1/11", ready, value); end
    index = 2; #1;
    checks++; if (ready !== 1'b1 || value !== 32'd22) begin errors++; $display("FAIL dual_port2 got %0b/%0d exp 1/22", ready, value); end
    cdb1(7, 77);
    cdb1(20, 99);
    index = 7; #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_entry_write got %0b exp 0", ready); end
    index = 4; #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL big_tag_write got %0b exp 0", ready); end
    checks++; if (count !== 5'd5 || commit_valid !== 1'b0) begin errors++; $display("FAIL dual_no_commit got c%0d v%0b exp c5 v0", count, commit_valid); end
  endtask
  task automatic test_lookup;
    index = 16; #1;
    checks++; if (ready !== 1'b0 || value !== 32'd0) begin errors++; $display("FAIL lookup_16 got %0b/%h exp 0/0", ready, value); end
    index = 4; CDBiscast = 1; CDBrobNum = 4; CDBdata = 32'hA; #1;
    checks++; if (ready !== BYP || value !== (BYP ? 32'hA : 32'h0)) begin errors++; $display("FAIL lookup_bypass got %0b/%h exp %0b/%h", ready, value, BYP, BYP ? 32'hA : 32'h0); end
    tick();
    CDBiscast = 1; CDBrobNum = 4; CDBdata = 32'hB; #1;
    checks++; if (ready !== 1'b1 || value !== 32'hA) begin errors++; $display("FAIL lookup_stored got %0b/%h exp 1/a", ready, value); end
    CDBiscast = 0;
  endtask
  task automatic test_flush;
    do_reset();
    alloc_n(5);
    cdb1(0, 32'h40);
    flush = 1; alloc_valid = 1; alloc_dest = 3; CDBiscast = 1; CDBrobNum = 1; CDBdata = 32'h55;
    tick();
    idle();
    checks++; if (count !== 5'd0 || commit_valid !== 1'b0 || alloc_robNum !== 6'd0 || alloc_ready !== 1'b1)
      begin errors++; $display("FAIL flush_state got c%0d v%0b t%0d rdy%0b exp c0 v0 t0 rdy1", count, commit_valid, alloc_robNum, alloc_ready); end
    index = 1; #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_cdb_lost got %0b exp 0", ready); end
    alloc_n(1);
    index = 0; #1;
    checks++; if (count !== 5'd1 || alloc_robNum !== 6'd1 || ready !== 1'b0)
      begin errors++; $display("FAIL flush_realloc got c%0d t%0d rdy%0b exp c1 t1 rdy0", count, alloc_robNum, ready); end
    tick();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL flush_no_commit got %0b exp 0", commit_valid); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_out_of_order();
    test_full_wrap();
    test_dual_cdb();
    test_lookup();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
